data_ram_arbiter: RTL and testbench

Shares the single-port 128x8 data RAM between two requesters: port 0 is the CPU core's fetch/execute datapath and port 1 is the debug/DMA master. It performs one RAM access per cycle with fixed CPU priority and a starvation guard for port 1. A lock mechanism gives one port exclusive access for read-modify-write sequences such as BCF, BSF, INCF and DECFSZ. It sits between both masters and the `single_port_ram_128x8` instance, and drives the RAM's address, data and write-enable pins.

---
 rtl/data_ram_arbiter_if.sv | 48 ++++
 rtl/data_ram_arbiter.sv | 121 ++++++++++++
 tb/tb_data_ram_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/data_ram_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the single-port data RAM.
// The slave view belongs to the arbiter; the master view is the requesters plus RAM side.
interface data_ram_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              p0_req;
    logic              p0_we;
    logic              p0_lock;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic              p1_lock;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_en;
    logic [DATA_W-1:0] ram_q;
    logic              lock_abort;

    modport slave (
        input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        input  ram_q,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output ram_addr, ram_data, ram_en, lock_abort
    );

    modport master (
        output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        output ram_q,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  ram_addr, ram_data, ram_en, lock_abort
    );
endinterface

// File: rtl/data_ram_arbiter.sv
// Two-port arbiter for the single-port 128x8 data RAM: CPU-first priority, starvation
// guard for the debug/DMA port, and a timed lock for read-modify-write sequences.
module data_ram_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    data_ram_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
    localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

    state_e            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              gnt0, gnt1, abort;
    logic [ADDR_W-1:0] addr_mux;

    // Grant decision; everything is forced quiet while rst is high.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        abort = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.p0_req && bus.p1_req) begin
                        if (wait_cnt_q == WAIT_LIM) gnt1 = 1'b1;
                        else                        gnt0 = 1'b1;
                    end else begin
                        gnt0 = bus.p0_req;
                        gnt1 = bus.p1_req;
                    end
                end
                OWN0: begin
                    gnt0  = bus.p0_req;
                    abort = (lock_cnt_q == LOCK_LIM);
                end
                OWN1: begin
                    gnt1  = bus.p1_req;
                    abort = (lock_cnt_q == LOCK_LIM);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            IDLE: begin
                lock_cnt_d = '0;
                if (gnt0 && bus.p0_lock)      state_d = OWN0;
                else if (gnt1 && bus.p1_lock) state_d = OWN1;
            end
            OWN0: begin
                lock_cnt_d = lock_cnt_q + 8'd1;
                if (abort || !bus.p0_req || (gnt0 && !bus.p0_lock)) state_d = IDLE;
            end
            OWN1: begin
                lock_cnt_d = lock_cnt_q + 8'd1;
                if (abort || !bus.p1_req || (gnt1 && !bus.p1_lock)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wait_cnt_d = '0;
        if (bus.p1_req && !gnt1)
            wait_cnt_d = (wait_cnt_q == WAIT_LIM) ? wait_cnt_q : wait_cnt_q + 4'd1;

        if (rst)       addr_mux = '0;
        else if (gnt0) addr_mux = bus.p0_addr;
        else if (gnt1) addr_mux = bus.p1_addr;
        else           addr_mux = addr_q;
        addr_d = addr_mux;

        rvalid0_d = gnt0 && !bus.p0_we;
        rvalid1_d = gnt1 && !bus.p1_we;
    end

    always_comb begin
        bus.p0_gnt     = gnt0;
        bus.p1_gnt     = gnt1;
        bus.ram_addr   = addr_mux;
        bus.ram_data   = gnt0 ? bus.p0_wdata : (gnt1 ? bus.p1_wdata : '0);
        bus.ram_en     = (gnt0 && bus.p0_we) || (gnt1 && bus.p1_we);
        // Gating with rst drops a read return that is still in the register.
        bus.p0_rvalid  = rvalid0_q && !rst;
        bus.p1_rvalid  = rvalid1_q && !rst;
        bus.p0_rdata   = bus.ram_q;
        bus.p1_rdata   = bus.ram_q;
        bus.lock_abort = abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            lock_cnt_q <= '0;
            addr_q     <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            addr_q     <= addr_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a behavioural 128x8 synchronous RAM attached.
module tb_data_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_ram_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus ();

    data_ram_arbiter #(.ADDR_W(7), .DATA_W(8), .MAX_WAIT(4), .LOCK_MAX(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [0:127];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        bus.ram_q = 8'h00;
    end
    always @(posedge clk) begin
        if (bus.ram_en) mem[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= bus.ram_en ? bus.ram_data : mem[bus.ram_addr];
    end

    typedef struct {
        logic       rst;
        logic       r0, w0, l0;
        logic [6:0] a0;
        logic [7:0] d0;
        logic       r1, w1, l1;
        logic [6:0] a1;
        logic [7:0] d1;
        logic       g0, g1, en;
        logic [6:0] addr;
        logic       v0, v1;
        logic [7:0] rd;
        logic       ab;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(
        logic r, logic r0, logic w0, logic l0, logic [6:0] a0, logic [7:0] d0,
        logic r1, logic w1, logic l1, logic [6:0] a1, logic [7:0] d1,
        logic g0, logic g1, logic en, logic [6:0] addr,
        logic v0, logic v1, logic [7:0] rd, logic ab);
        vec_t v;
        v.rst = r;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.en = en; v.addr = addr;
        v.v0 = v0; v.v1 = v1; v.rd = rd; v.ab = ab;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst          = v.rst;
        bus.p0_req   = v.r0; bus.p0_we = v.w0; bus.p0_lock = v.l0;
        bus.p0_addr  = v.a0; bus.p0_wdata = v.d0;
        bus.p1_req   = v.r1; bus.p1_we = v.w1; bus.p1_lock = v.l1;
        bus.p1_addr  = v.a1; bus.p1_wdata = v.d1;
    endtask

    vec_t vecs [21];

    initial begin
        vecs[0]  = mk(1, 1,0,0,7'h0D,8'h00, 1,0,0,7'h20,8'h00, 0,0,0,7'h00, 0,0,8'h00, 0);
        vecs[1]  = mk(0, 1,1,0,7'h0D,8'h5A, 0,0,0,7'h00,8'h00, 1,0,1,7'h0D, 0,0,8'h00, 0);
        vecs[2]  = mk(0, 1,0,0,7'h0D,8'h00, 0,0,0,7'h00,8'h00, 1,0,0,7'h0D, 0,0,8'h00, 0);
        vecs[3]  = mk(0, 0,0,0,7'h00,8'h00, 0,0,0,7'h00,8'h00, 0,0,0,7'h0D, 1,0,8'h5A, 0);
        vecs[4]  = mk(0, 0,0,0,7'h00,8'h00, 1,1,0,7'h20,8'h07, 0,1,1,7'h20, 0,0,8'h00, 0);
        vecs[5]  = mk(0, 0,0,0,7'h00,8'h00, 1,0,0,7'h20,8'h00, 0,1,0,7'h20, 0,0,8'h00, 0);
        vecs[6]  = mk(0, 0,0,0,7'h00,8'h00, 0,0,0,7'h00,8'h00, 0,0,0,7'h20, 0,1,8'h07, 0);
        vecs[7]  = mk(0, 1,0,1,7'h20,8'h00, 1,1,0,7'h30,8'h99, 1,0,0,7'h20, 0,0,8'h00, 0);
        vecs[8]  = mk(0, 1,1,0,7'h20,8'h21, 1,1,0,7'h30,8'h99, 1,0,1,7'h20, 1,0,8'h07, 0);
        vecs[9]  = mk(0, 0,0,0,7'h00,8'h00, 1,1,0,7'h30,8'h99, 0,1,1,7'h30, 0,0,8'h00, 0);
        vecs[10] = mk(0, 0,0,0,7'h00,8'h00, 1,0,0,7'h20,8'h00, 0,1,0,7'h20, 0,0,8'h00, 0);
        vecs[11] = mk(0, 0,0,0,7'h00,8'h00, 0,0,0,7'h00,8'h00, 0,0,0,7'h20, 0,1,8'h21, 0);
        vecs[12] = mk(0, 1,0,1,7'h05,8'h00, 0,0,0,7'h00,8'h00, 1,0,0,7'h05, 0,0,8'h00, 0);
        vecs[13] = mk(0, 0,0,0,7'h05,8'h00, 1,0,0,7'h30,8'h00, 0,0,0,7'h05, 1,0,8'h00, 0);
        vecs[14] = mk(0, 0,0,0,7'h00,8'h00, 1,0,0,7'h30,8'h00, 0,1,0,7'h30, 0,0,8'h00, 0);
        vecs[15] = mk(0, 0,0,0,7'h00,8'h00, 0,0,0,7'h00,8'h00, 0,0,0,7'h30, 0,1,8'h99, 0);
        vecs[16] = mk(0, 0,0,0,7'h00,8'h00, 1,0,1,7'h30,8'h00, 0,1,0,7'h30, 0,0,8'h00, 0);
        vecs[17] = mk(0, 1,0,0,7'h0D,8'h00, 1,0,1,7'h20,8'h00, 0,1,0,7'h20, 0,1,8'h99, 0);
        vecs[18] = mk(1, 1,0,0,7'h0D,8'h00, 1,0,1,7'h20,8'h00, 0,0,0,7'h00, 0,0,8'h00, 0);
        vecs[19] = mk(0, 1,0,0,7'h0D,8'h00, 1,0,0,7'h20,8'h00, 1,0,0,7'h0D, 0,0,8'h00, 0);
        vecs[20] = mk(0, 0,0,0,7'h00,8'h00, 0,0,0,7'h00,8'h00, 0,0,0,7'h0D, 1,0,8'h5A, 0);

        drive(mk(1, 0,0,0,7'h00,8'h00, 0,0,0,7'h00,8'h00, 0,0,0,7'h00, 0,0,8'h00, 0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            chk("p0_gnt",     i, 32'(bus.p0_gnt),     32'(vecs[i].g0));
            chk("p1_gnt",     i, 32'(bus.p1_gnt),     32'(vecs[i].g1));
            chk("ram_en",     i, 32'(bus.ram_en),     32'(vecs[i].en));
            chk("ram_addr",   i, 32'(bus.ram_addr),   32'(vecs[i].addr));
            chk("p0_rvalid",  i, 32'(bus.p0_rvalid),  32'(vecs[i].v0));
            chk("p1_rvalid",  i, 32'(bus.p1_rvalid),  32'(vecs[i].v1));
            chk("lock_abort", i, 32'(bus.lock_abort), 32'(vecs[i].ab));
            if (vecs[i].v0) chk("p0_rdata", i, 32'(bus.p0_rdata), 32'(vecs[i].rd));
            if (vecs[i].v1) chk("p1_rdata", i, 32'(bus.p1_rdata), 32'(vecs[i].rd));
        end

        // Contention: both ports request every cycle; p1 gets through every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(mk(0, 1,0,0,7'h00,8'h00, 1,0,0,7'h01,8'h00, 0,0,0,7'h00, 0,0,8'h00, 0));
            @(negedge clk);
            chk("cont_p0_gnt", 100 + i, 32'(bus.p0_gnt), 32'((i % 5) != 4));
            chk("cont_p1_gnt", 100 + i, 32'(bus.p1_gnt), 32'((i % 5) == 4));
            if ((i % 5) == 4) chk("cont_ram_addr", 100 + i, 32'(bus.ram_addr), 32'h01);
        end
        @(posedge clk); #1;
        drive(mk(0, 0,0,0,7'h00,8'h00, 0,0,0,7'h00,8'h00, 0,0,0,7'h00, 0,0,8'h00, 0));

        // Lock timeout: p1 locks alone, then keeps lock=1 while p0 waits.
        begin
            int aborts;
            aborts = 0;
            @(posedge clk); #1;
            drive(mk(0, 0,0,0,7'h00,8'h00, 1,0,1,7'h10,8'h00, 0,0,0,7'h00, 0,0,8'h00, 0));
            @(negedge clk);
            chk("to_take_gnt", 200, 32'(bus.p1_gnt), 32'h1);
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk); #1;
                drive(mk(0, 1,0,0,7'h00,8'h00, 1,0,1,7'h10,8'h00, 0,0,0,7'h00, 0,0,8'h00, 0));
                @(negedge clk);
                if (bus.lock_abort === 1'b1) aborts++;
                chk("to_p1_gnt", 200 + k, 32'(bus.p1_gnt),     32'(k <= 9));
                chk("to_p0_gnt", 200 + k, 32'(bus.p0_gnt),     32'(k == 10));
                chk("to_abort",  200 + k, 32'(bus.lock_abort), 32'(k == 9));
            end
            chk("to_abort_count", 211, 32'(aborts), 32'd1);
        end

        @(posedge clk); #1;
        drive(mk(0, 0,0,0,7'h00,8'h00, 0,0,0,7'h00,8'h00, 0,0,0,7'h00, 0,0,8'h00, 0));
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
